// File: rtl/lcd_frame_sched.sv
// Frame-level controller for the LTM LCD scanner. Pulses the scanner start,
// latches mode/RGB once per frame, counts completed frames and arbitrates the
// shared framebuffer between display fetch (priority) and a drawing writer.
module lcd_frame_sched #(
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned X_ACTIVE   = 800,
  parameter int unsigned Y_ACTIVE   = 480
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic        i_mode_req,
  input  logic [2:0]  i_rgb_req,
  output logic        o_lcd_start,
  output logic        o_lcd_mode,
  output logic [2:0]  o_lcd_rgb,
  input  logic        i_lcd_done,
  input  logic [9:0]  i_lcd_addrX,
  input  logic [8:0]  i_lcd_addrY,
  output logic [7:0]  o_lcd_data,
  input  logic        i_wr_valid,
  input  logic [9:0]  i_wr_addrX,
  input  logic [8:0]  i_wr_addrY,
  input  logic [7:0]  i_wr_data,
  output logic        o_wr_ready,
  output logic [18:0] o_mem_addr,
  output logic        o_mem_we,
  output logic [7:0]  o_mem_wdata,
  input  logic [7:0]  i_mem_rdata,
  output logic [15:0] o_frame_cnt,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWaitClr,
    StScan,
    StGap
  } state_e;

  // One extra bit so a limit of exactly 1024/512 still compares correctly.
  localparam logic [10:0] XLim    = 11'(X_ACTIVE);
  localparam logic [9:0]  YLim    = 10'(Y_ACTIVE);
  localparam logic [15:0] GapLast = 16'(GAP_CYCLES - 1);

  state_e      state_q;
  logic        start_cnt_q;
  logic [15:0] gap_cnt_q;

  logic disp_own;
  logic wr_in_range;
  logic wr_xfer;

  // Frame sequencing: start pulse, done handshake, inter-frame gap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= StIdle;
      start_cnt_q <= 1'b0;
      gap_cnt_q   <= '0;
      o_lcd_start <= 1'b0;
      o_lcd_mode  <= 1'b0;
      o_lcd_rgb   <= '0;
      o_frame_cnt <= '0;
      o_busy      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_enable) begin
            state_q     <= StStart;
            start_cnt_q <= 1'b0;
            o_lcd_start <= 1'b1;
            o_lcd_mode  <= i_mode_req;
            o_lcd_rgb   <= i_rgb_req;
            o_busy      <= 1'b1;
          end
        end
        StStart: begin
          // Start stays high for two cycles; the scanner restarts on the fall.
          if (start_cnt_q) begin
            state_q     <= StWaitClr;
            o_lcd_start <= 1'b0;
          end else begin
            start_cnt_q <= 1'b1;
          end
        end
        StWaitClr: begin
          // Done may be stale (clear latency or power-up value); wait it out.
          if (!i_lcd_done) begin
            state_q <= StScan;
          end
        end
        StScan: begin
          if (i_lcd_done) begin
            state_q     <= StGap;
            gap_cnt_q   <= '0;
            o_frame_cnt <= o_frame_cnt + 16'd1;
          end
        end
        StGap: begin
          if (gap_cnt_q == GapLast) begin
            gap_cnt_q <= '0;
            if (i_enable) begin
              state_q     <= StStart;
              start_cnt_q <= 1'b0;
              o_lcd_start <= 1'b1;
              o_lcd_mode  <= i_mode_req;
              o_lcd_rgb   <= i_rgb_req;
            end else begin
              state_q <= StIdle;
              o_busy  <= 1'b0;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Memory arbitration: display fetch wins, writer takes any free cycle.
  always_comb begin
    disp_own = (state_q == StScan) && !o_lcd_mode &&
               ({1'b0, i_lcd_addrX} < XLim) && ({1'b0, i_lcd_addrY} < YLim);
    wr_in_range = ({1'b0, i_wr_addrX} < XLim) && ({1'b0, i_wr_addrY} < YLim);
    o_wr_ready  = !disp_own;
    wr_xfer     = i_wr_valid && o_wr_ready;

    o_mem_addr  = '0;
    o_mem_we    = 1'b0;
    o_mem_wdata = '0;
    o_lcd_data  = '0;
    if (disp_own) begin
      o_mem_addr = {i_lcd_addrY, i_lcd_addrX};
      o_lcd_data = i_mem_rdata;
    end else if (wr_xfer) begin
      // Out-of-range writes complete the handshake but never reach memory.
      o_mem_addr  = {i_wr_addrY, i_wr_addrX};
      o_mem_we    = wr_in_range;
      o_mem_wdata = i_wr_data;
    end
  end

endmodule

// File: tb/tb_lcd_frame_sched.sv
// Directed bench for lcd_frame_sched with hand-computed expectations.
module tb_lcd_frame_sched;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_enable;
  logic        i_mode_req;
  logic [2:0]  i_rgb_req;
  logic        o_lcd_start;
  logic        o_lcd_mode;
  logic [2:0]  o_lcd_rgb;
  logic        i_lcd_done;
  logic [9:0]  i_lcd_addrX;
  logic [8:0]  i_lcd_addrY;
  logic [7:0]  o_lcd_data;
  logic        i_wr_valid;
  logic [9:0]  i_wr_addrX;
  logic [8:0]  i_wr_addrY;
  logic [7:0]  i_wr_data;
  logic        o_wr_ready;
  logic [18:0] o_mem_addr;
  logic        o_mem_we;
  logic [7:0]  o_mem_wdata;
  logic [7:0]  i_mem_rdata;
  logic [15:0] o_frame_cnt;
  logic        o_busy;

  int errors = 0;
  int checks = 0;

  lcd_frame_sched #(
    .GAP_CYCLES(16),
    .X_ACTIVE  (800),
    .Y_ACTIVE  (480)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_enable   (i_enable),
    .i_mode_req (i_mode_req),
    .i_rgb_req  (i_rgb_req),
    .o_lcd_start(o_lcd_start),
    .o_lcd_mode (o_lcd_mode),
    .o_lcd_rgb  (o_lcd_rgb),
    .i_lcd_done (i_lcd_done),
    .i_lcd_addrX(i_lcd_addrX),
    .i_lcd_addrY(i_lcd_addrY),
    .o_lcd_data (o_lcd_data),
    .i_wr_valid (i_wr_valid),
    .i_wr_addrX (i_wr_addrX),
    .i_wr_addrY (i_wr_addrY),
    .i_wr_data  (i_wr_data),
    .o_wr_ready (o_wr_ready),
    .o_mem_addr (o_mem_addr),
    .o_mem_we   (o_mem_we),
    .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata),
    .o_frame_cnt(o_frame_cnt),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_rst       = 1'b1;
    i_enable    = 1'b0;
    i_mode_req  = 1'b0;
    i_rgb_req   = 3'b000;
    i_lcd_done  = 1'b1;
    i_lcd_addrX = 10'd5;
    i_lcd_addrY = 9'd7;
    i_wr_valid  = 1'b0;
    i_wr_addrX  = 10'd0;
    i_wr_addrY  = 9'd0;
    i_wr_data   = 8'h00;
    i_mem_rdata = 8'h3C;
    #12;
    chk("rst_start", o_lcd_start, 0);
    chk("rst_mode", o_lcd_mode, 0);
    chk("rst_rgb", o_lcd_rgb, 0);
    chk("rst_cnt", o_frame_cnt, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_we", o_mem_we, 0);
    chk("rst_addr", o_mem_addr, 0);
    chk("rst_ready", o_wr_ready, 1);

    // Frame 1: stroke mode.
    step();
    i_rst = 1'b0;
    step();
    chk("idle_busy", o_busy, 0);
    i_enable = 1'b1;
    step();
    chk("f1_start_c1", o_lcd_start, 1);
    chk("f1_busy", o_busy, 1);
    step();
    chk("f1_start_c2", o_lcd_start, 1);
    step();
    chk("f1_start_low", o_lcd_start, 0);
    // Stale done holds the FSM in WAIT_CLR; display not owner there.
    step();
    chk("waitclr_busy", o_busy, 1);
    chk("waitclr_ready", o_wr_ready, 1);
    i_lcd_done = 1'b0;
    step();
    // Now SCAN, stroke, display address in range; writer at (799,479).
    i_wr_valid = 1'b1;
    i_wr_addrX = 10'd799;
    i_wr_addrY = 9'd479;
    i_wr_data  = 8'hAA;
    #1;
    chk("scan_ready_stall", o_wr_ready, 0);
    chk("scan_disp_addr", o_mem_addr, {13'd0, 9'd7, 10'd5});
    chk("scan_disp_we", o_mem_we, 0);
    chk("scan_lcd_data", o_lcd_data, 8'h3C);
    // Horizontal blanking: X out of range, writer gets the slot.
    i_lcd_addrX = 10'd800;
    #1;
    chk("hblank_ready", o_wr_ready, 1);
    chk("hblank_addr", o_mem_addr, {13'd0, 9'd479, 10'd799});
    chk("hblank_we", o_mem_we, 1);
    chk("hblank_wdata", o_mem_wdata, 8'hAA);
    chk("hblank_lcd_data", o_lcd_data, 0);
    // Vertical blanking: Y out of range.
    i_lcd_addrX = 10'd0;
    i_lcd_addrY = 9'd480;
    #1;
    chk("vblank_ready", o_wr_ready, 1);
    chk("vblank_we", o_mem_we, 1);
    i_wr_valid = 1'b0;
    #1;
    chk("noone_addr", o_mem_addr, 0);
    chk("noone_wdata", o_mem_wdata, 0);
    i_lcd_addrX = 10'd5;
    i_lcd_addrY = 9'd7;
    // Requests for next frame; must not disturb the current one.
    i_mode_req = 1'b1;
    i_rgb_req  = 3'b101;
    i_lcd_done = 1'b1;
    step();
    chk("f1_cnt", o_frame_cnt, 1);
    chk("f1_mode_held", o_lcd_mode, 0);
    for (int i = 0; i < 15; i++) begin
      step();
      chk("gap_no_start", o_lcd_start, 0);
    end
    step();
    chk("gap_start_16", o_lcd_start, 1);
    chk("f2_mode", o_lcd_mode, 1);
    chk("f2_rgb", o_lcd_rgb, 3'b101);

    // Frame 2: color mode.
    i_rgb_req = 3'b010;
    step();
    step();
    chk("f2_start_low", o_lcd_start, 0);
    i_lcd_done = 1'b0;
    step();
    i_wr_valid = 1'b1;
    i_wr_addrX = 10'd10;
    i_wr_addrY = 9'd20;
    i_wr_data  = 8'h55;
    #1;
    chk("color_ready", o_wr_ready, 1);
    chk("color_we", o_mem_we, 1);
    chk("color_addr", o_mem_addr, {13'd0, 9'd20, 10'd10});
    chk("color_lcd_data", o_lcd_data, 0);
    chk("color_rgb_held", o_lcd_rgb, 3'b101);
    i_wr_addrX = 10'd800;
    #1;
    chk("oor_x_ready", o_wr_ready, 1);
    chk("oor_x_we", o_mem_we, 0);
    i_wr_addrX = 10'd10;
    i_wr_addrY = 9'd480;
    #1;
    chk("oor_y_ready", o_wr_ready, 1);
    chk("oor_y_we", o_mem_we, 0);
    i_wr_valid = 1'b0;
    // Drop enable mid-SCAN: frame and gap still complete.
    i_enable = 1'b0;
    step();
    chk("f2_scan_busy", o_busy, 1);
    i_lcd_done = 1'b1;
    step();
    chk("f2_cnt", o_frame_cnt, 2);
    for (int i = 0; i < 15; i++) step();
    chk("gap_end_busy", o_busy, 1);
    step();
    chk("idle_busy_after", o_busy, 0);
    chk("idle_no_start", o_lcd_start, 0);
    step();
    chk("idle_cnt_stable", o_frame_cnt, 2);

    // Frame 3: reset mid-SCAN.
    i_mode_req = 1'b0;
    i_enable   = 1'b1;
    step();
    chk("f3_rgb", o_lcd_rgb, 3'b010);
    chk("f3_mode", o_lcd_mode, 0);
    step();
    step();
    i_lcd_done = 1'b0;
    step();
    #1;
    chk("f3_scan_ready", o_wr_ready, 0);
    #2;
    i_rst = 1'b1;
    #1;
    chk("mrst_start", o_lcd_start, 0);
    chk("mrst_rgb", o_lcd_rgb, 0);
    chk("mrst_cnt", o_frame_cnt, 0);
    chk("mrst_busy", o_busy, 0);
    chk("mrst_ready", o_wr_ready, 1);
    step();
    i_rst = 1'b0;
    step();
    chk("rs_start_c1", o_lcd_start, 1);
    step();
    chk("rs_start_c2", o_lcd_start, 1);
    step();
    chk("rs_start_low", o_lcd_start, 0);
    step();
    chk("rs_scan_ready", o_wr_ready, 0);
    i_lcd_done = 1'b1;
    step();
    chk("rs_cnt", o_frame_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
